// File: rtl/cpu_icache_pkg.sv
// Shared types for the instruction-cache arbiter: request slot and response bus layouts.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_icache_pkg;

  localparam int ICACHE_TAG_W = 9;
  localparam int REQ_TAG_W    = ICACHE_TAG_W - 1;

  localparam logic SRC_IFETCH = 1'b0;
  localparam logic SRC_LOADER = 1'b1;

  typedef struct packed {
    logic [31:0]          address;
    logic                 src;
    logic [REQ_TAG_W-1:0] tag;
  } icache_req_t;

  typedef struct packed {
    logic [31:0]             rdata;
    logic [31:0]             raddr;
    logic [ICACHE_TAG_W-1:0] rtag;
  } icache_resp_t;

  // The cache has no tag sideband on the request side, so {src, tag} rides in the low wdata bits.
  function automatic logic [31:0] pack_tag_wdata(input logic src, input logic [REQ_TAG_W-1:0] tag);
    return {{(32-ICACHE_TAG_W){1'b0}}, src, tag};
  endfunction

endpackage

// File: rtl/cpu_icache_arb_cnt.sv
// Outstanding-read counter for one requester, with limit flag and underflow detect.
// Latency: flags are combinational from the registered count; count updates next edge.
// Backpressure: at_limit is used upstream to withhold the requester's ready.
module cpu_icache_arb_cnt
  import cpu_icache_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic dec,
  output logic at_limit,
  output logic underflow
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] cnt_q;

  assign at_limit  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  // A response with nothing outstanding is only an error if no grant lands in the same cycle.
  assign underflow = dec & ~inc & (cnt_q == '0);

  // Count grants up and routed responses down; a simultaneous pair cancels, underflow never wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (inc & ~dec) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (dec & ~inc & (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_icache_arb.sv
// Round-robin arbiter between ifetch (m0) and loader (m1) onto one tagged icache read port.
// Latency: accept in N -> icache_request in N+1; icache_rvalid in N -> m*_rvalid in N+1.
// Backpressure: one-entry output slot; ready drops while the slot is stalled or a requester is at its limit.
module cpu_icache_arb
  import cpu_icache_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_W           = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             m0_request,
  output logic             m0_ready,
  input  logic [31:0]      m0_address,
  input  logic [TAG_W-1:0] m0_tag,
  output logic [31:0]      m0_rdata,
  output logic [31:0]      m0_raddr,
  output logic [TAG_W-1:0] m0_rtag,
  output logic             m0_rvalid,
  input  logic             m1_request,
  output logic             m1_ready,
  input  logic [31:0]      m1_address,
  input  logic [TAG_W-1:0] m1_tag,
  output logic [31:0]      m1_rdata,
  output logic [31:0]      m1_raddr,
  output logic [TAG_W-1:0] m1_rtag,
  output logic             m1_rvalid,
  output logic             icache_request,
  input  logic             icache_ready,
  output logic [31:0]      icache_address,
  output logic             icache_write,
  output logic             icache_burst,
  output logic [3:0]       icache_wstrb,
  output logic [31:0]      icache_wdata,
  input  logic [31:0]      icache_rdata,
  input  logic [31:0]      icache_raddr,
  input  logic [TAG_W:0]   icache_rtag,
  input  logic             icache_rvalid,
  output logic             arb_error
);

  icache_req_t  slot_q;
  icache_resp_t resp_in;
  logic         req_q;
  logic         rr_last_q;
  logic         slot_free;
  logic         elig0, elig1;
  logic         grant0, grant1;
  logic         at_limit0, at_limit1;
  logic         underflow0, underflow1;
  logic         rsp0, rsp1;

  assign resp_in   = '{rdata: icache_rdata, raddr: icache_raddr, rtag: icache_rtag};
  assign rsp0      = icache_rvalid & (resp_in.rtag[ICACHE_TAG_W-1] == SRC_IFETCH);
  assign rsp1      = icache_rvalid & (resp_in.rtag[ICACHE_TAG_W-1] == SRC_LOADER);
  assign slot_free = ~req_q | icache_ready;

  // Grant only into a free slot; on a tie, serve whichever requester was not served last.
  always_comb begin
    elig0  = m0_request & ~at_limit0;
    elig1  = m1_request & ~at_limit1;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (slot_free) begin
      if (elig0 && elig1) begin
        grant0 = rr_last_q;
        grant1 = ~rr_last_q;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign m0_ready = grant0;
  assign m1_ready = grant1;

  // Output slot: load on grant, drain when the cache takes it, otherwise hold stable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q     <= 1'b0;
      slot_q    <= '0;
      rr_last_q <= 1'b1;
    end else if (grant0 | grant1) begin
      req_q          <= 1'b1;
      slot_q.address <= grant1 ? m1_address : m0_address;
      slot_q.src     <= grant1 ? SRC_LOADER : SRC_IFETCH;
      slot_q.tag     <= grant1 ? m1_tag : m0_tag;
      rr_last_q      <= grant1;
    end else if (icache_ready) begin
      req_q <= 1'b0;
    end
  end

  assign icache_request = req_q;
  assign icache_address = slot_q.address;
  assign icache_wdata   = pack_tag_wdata(slot_q.src, slot_q.tag);
  assign icache_write   = 1'b0;
  assign icache_burst   = 1'b0;
  assign icache_wstrb   = 4'b0000;

  cpu_icache_arb_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt0 (
    .clock     (clock),
    .reset_n   (reset_n),
    .inc       (grant0),
    .dec       (rsp0),
    .at_limit  (at_limit0),
    .underflow (underflow0)
  );

  cpu_icache_arb_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .inc       (grant1),
    .dec       (rsp1),
    .at_limit  (at_limit1),
    .underflow (underflow1)
  );

  // Route responses by source bit; each requester's data holds between its own responses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m0_raddr  <= '0;
      m0_rtag   <= '0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_raddr  <= '0;
      m1_rtag   <= '0;
    end else begin
      m0_rvalid <= rsp0;
      m1_rvalid <= rsp1;
      if (rsp0) begin
        m0_rdata <= resp_in.rdata;
        m0_raddr <= resp_in.raddr;
        m0_rtag  <= resp_in.rtag[TAG_W-1:0];
      end
      if (rsp1) begin
        m1_rdata <= resp_in.rdata;
        m1_raddr <= resp_in.raddr;
        m1_rtag  <= resp_in.rtag[TAG_W-1:0];
      end
    end
  end

  // Sticky flag for a response that has no matching outstanding read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      arb_error <= 1'b0;
    end else if (underflow0 | underflow1) begin
      arb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_icache_arb.sv
module tb_cpu_icache_arb;

  localparam int MAXO = 4;

  logic        clock;
  logic        reset_n;
  logic        m0_request, m1_request;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_address, m1_address;
  logic [7:0]  m0_tag, m1_tag;
  logic [31:0] m0_rdata, m0_raddr, m1_rdata, m1_raddr;
  logic [7:0]  m0_rtag, m1_rtag;
  logic        m0_rvalid, m1_rvalid;
  logic        icache_request, icache_ready;
  logic [31:0] icache_address, icache_wdata, icache_rdata, icache_raddr;
  logic        icache_write, icache_burst;
  logic [3:0]  icache_wstrb;
  logic [8:0]  icache_rtag;
  logic        icache_rvalid;
  logic        arb_error;

  cpu_icache_arb #(.MAX_OUTSTANDING(MAXO), .TAG_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_request(m0_request), .m0_ready(m0_ready), .m0_address(m0_address), .m0_tag(m0_tag),
    .m0_rdata(m0_rdata), .m0_raddr(m0_raddr), .m0_rtag(m0_rtag), .m0_rvalid(m0_rvalid),
    .m1_request(m1_request), .m1_ready(m1_ready), .m1_address(m1_address), .m1_tag(m1_tag),
    .m1_rdata(m1_rdata), .m1_raddr(m1_raddr), .m1_rtag(m1_rtag), .m1_rvalid(m1_rvalid),
    .icache_request(icache_request), .icache_ready(icache_ready),
    .icache_address(icache_address), .icache_write(icache_write), .icache_burst(icache_burst),
    .icache_wstrb(icache_wstrb), .icache_wdata(icache_wdata),
    .icache_rdata(icache_rdata), .icache_raddr(icache_raddr), .icache_rtag(icache_rtag),
    .icache_rvalid(icache_rvalid), .arb_error(arb_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: what the arbiter must look like, kept as plain counts and records.
  int          m_cnt [2];
  int          m_last;
  bit          m_req;
  logic [31:0] m_addr, m_wdata;
  bit          m_rv  [2];
  logic [31:0] m_rd  [2];
  logic [31:0] m_ra  [2];
  logic [7:0]  m_rt  [2];
  bit          m_err;
  int          mg, msrc;
  bit          mfree, mel0, mel1, minc, mdec;

  // Every cycle: predict readies from the model, compare all outputs, then advance the model.
  always @(negedge clock) begin
    if (!reset_n) begin
      m_cnt[0] = 0; m_cnt[1] = 0; m_last = 1; m_req = 0;
      m_addr = '0; m_wdata = '0; m_err = 0;
      for (int i = 0; i < 2; i++) begin
        m_rv[i] = 0; m_rd[i] = '0; m_ra[i] = '0; m_rt[i] = '0;
      end
    end
    mfree = !m_req || icache_ready;
    mel0  = m0_request && (m_cnt[0] < MAXO);
    mel1  = m1_request && (m_cnt[1] < MAXO);
    mg    = -1;
    if (mfree) begin
      if (mel0 && mel1) mg = (m_last == 0) ? 1 : 0;
      else if (mel0)    mg = 0;
      else if (mel1)    mg = 1;
    end
    chk("m0_ready", 32'(m0_ready), 32'(mg == 0));
    chk("m1_ready", 32'(m1_ready), 32'(mg == 1));
    chk("icache_request", 32'(icache_request), 32'(m_req));
    if (m_req) begin
      chk("icache_address", icache_address, m_addr);
      chk("icache_wdata", icache_wdata, m_wdata);
    end
    chk("tied_ctrl", {27'b0, icache_write, icache_burst, icache_wstrb}, 32'h0);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(m_rv[0]));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(m_rv[1]));
    chk("m0_rdata", m0_rdata, m_rd[0]);
    chk("m0_raddr", m0_raddr, m_ra[0]);
    chk("m0_rtag", 32'(m0_rtag), 32'(m_rt[0]));
    chk("m1_rdata", m1_rdata, m_rd[1]);
    chk("m1_raddr", m1_raddr, m_ra[1]);
    chk("m1_rtag", 32'(m1_rtag), 32'(m_rt[1]));
    chk("arb_error", 32'(arb_error), 32'(m_err));
    if (reset_n) begin
      msrc = int'(icache_rtag[8]);
      for (int i = 0; i < 2; i++) begin
        minc = (mg == i);
        mdec = icache_rvalid && (msrc == i);
        if (mdec && !minc && m_cnt[i] == 0) m_err = 1;
        else m_cnt[i] = m_cnt[i] + int'(minc) - int'(mdec);
        m_rv[i] = mdec;
        if (mdec) begin
          m_rd[i] = icache_rdata;
          m_ra[i] = icache_raddr;
          m_rt[i] = icache_rtag[7:0];
        end
      end
      if (mg >= 0) begin
        m_req   = 1;
        m_addr  = (mg == 1) ? m1_address : m0_address;
        m_wdata = {23'b0, 1'(mg), ((mg == 1) ? m1_tag : m0_tag)};
        m_last  = mg;
      end else if (icache_ready) begin
        m_req = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic respond(input logic [8:0] tag, input logic [31:0] data);
    cyc();
    icache_rvalid = 1'b1;
    icache_rtag   = tag;
    icache_rdata  = data;
    icache_raddr  = data ^ 32'h5A5A_0000;
    cyc();
    icache_rvalid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    m0_request = 0; m1_request = 0;
    m0_address = '0; m1_address = '0; m0_tag = '0; m1_tag = '0;
    icache_ready = 1'b1; icache_rvalid = 1'b0;
    icache_rtag = '0; icache_rdata = '0; icache_raddr = '0;
    repeat (3) cyc();
    chk("reset icache_request", 32'(icache_request), 32'h0);
    chk("reset arb_error", 32'(arb_error), 32'h0);
    reset_n = 1'b1;

    // Single read from ifetch and its response.
    cyc();
    m0_request = 1; m0_address = 32'hFFFF_0010; m0_tag = 8'h05;
    #1;
    chk("single m0_ready", 32'(m0_ready), 32'h1);
    chk("single m1_ready", 32'(m1_ready), 32'h0);
    cyc();
    m0_request = 0;
    #1;
    chk("single icache_request", 32'(icache_request), 32'h1);
    chk("single icache_address", icache_address, 32'hFFFF_0010);
    chk("single icache_wdata", icache_wdata, 32'h0000_0005);
    cyc();
    icache_rvalid = 1; icache_rtag = 9'h005; icache_rdata = 32'hDEAD_BEEF; icache_raddr = 32'hFFFF_0010;
    cyc();
    icache_rvalid = 0;
    #1;
    chk("single m0_rvalid", 32'(m0_rvalid), 32'h1);
    chk("single m0_rtag", 32'(m0_rtag), 32'h05);
    chk("single m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("single m1_rvalid", 32'(m1_rvalid), 32'h0);
    cyc();
    chk("single rvalid pulse", 32'(m0_rvalid), 32'h0);

    // Contention: ifetch was served last, so the loader wins first and grants alternate.
    for (int k = 0; k < 4; k++) begin
      cyc();
      m0_request = 1; m1_request = 1;
      m0_address = 32'h1000 + 32'(k * 4); m0_tag = 8'h10 + 8'(k);
      m1_address = 32'h2000 + 32'(k * 4); m1_tag = 8'h20 + 8'(k);
      #1;
      chk("rr m1_ready", 32'(m1_ready), 32'(k % 2 == 0));
      chk("rr m0_ready", 32'(m0_ready), 32'(k % 2 == 1));
      if (k > 0) chk("rr slot src", 32'(icache_wdata[8]), 32'(k % 2 == 1));
    end
    cyc();
    m0_request = 0; m1_request = 0;
    #1;
    chk("rr last src", 32'(icache_wdata[8]), 32'h0);
    respond(9'h120, 32'h0000_2000);
    respond(9'h121, 32'h0000_2004);
    respond(9'h011, 32'h0000_1004);
    respond(9'h013, 32'h0000_100C);

    // Backpressure: slot stalls for three cycles and must hold.
    cyc();
    icache_ready = 0; m0_request = 1; m0_address = 32'hA000_0000; m0_tag = 8'h31;
    #1;
    chk("bp first grant", 32'(m0_ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      m0_request = 1; m1_request = 1;
      m0_address = 32'hBBBB_0000 + 32'(k); m1_address = 32'hCCCC_0000 + 32'(k);
      #1;
      chk("bp m0_ready", 32'(m0_ready), 32'h0);
      chk("bp m1_ready", 32'(m1_ready), 32'h0);
      chk("bp address hold", icache_address, 32'hA000_0000);
      chk("bp wdata hold", icache_wdata, 32'h0000_0031);
    end
    cyc();
    icache_ready = 1; m0_request = 0; m1_request = 1; m1_address = 32'hC000_0000; m1_tag = 8'h42;
    #1;
    chk("bp grant on ready", 32'(m1_ready), 32'h1);
    cyc();
    m1_request = 0;
    #1;
    chk("bp next address", icache_address, 32'hC000_0000);
    chk("bp next wdata", icache_wdata, 32'h0000_0142);
    respond(9'h031, 32'h1111_0000);
    respond(9'h142, 32'h2222_0000);

    // Limit: four ifetch reads fill its budget; loader is unaffected.
    for (int k = 0; k < 4; k++) begin
      cyc();
      m0_request = 1; m0_address = 32'h4000 + 32'(k * 4); m0_tag = 8'h50 + 8'(k);
      #1;
      chk("limit fill m0_ready", 32'(m0_ready), 32'h1);
    end
    cyc();
    m1_request = 1; m1_address = 32'h5000; m1_tag = 8'h60;
    #1;
    chk("limit blocks m0", 32'(m0_ready), 32'h0);
    chk("limit m1 granted", 32'(m1_ready), 32'h1);
    cyc();
    m1_request = 0;
    icache_rvalid = 1; icache_rtag = 9'h050; icache_rdata = 32'h3333_0000; icache_raddr = 32'h4000;
    #1;
    chk("limit same-cycle resp", 32'(m0_ready), 32'h0);
    cyc();
    icache_rvalid = 0;
    #1;
    chk("limit unblock", 32'(m0_ready), 32'h1);
    cyc();
    m0_request = 0;
    respond(9'h051, 32'h3333_0004);
    respond(9'h052, 32'h3333_0008);
    respond(9'h053, 32'h3333_000C);
    respond(9'h053, 32'h3333_0010);
    respond(9'h160, 32'h4444_0000);

    // Underflow: loader response with nothing outstanding.
    cyc();
    icache_rvalid = 1; icache_rtag = 9'h1AB; icache_rdata = 32'h1234_5678; icache_raddr = 32'h8765_4321;
    cyc();
    icache_rvalid = 0;
    #1;
    chk("uf arb_error", 32'(arb_error), 32'h1);
    chk("uf m1_rvalid", 32'(m1_rvalid), 32'h1);
    chk("uf m1_rtag", 32'(m1_rtag), 32'h0000_00AB);
    chk("uf m0_rvalid", 32'(m0_rvalid), 32'h0);
    cyc();
    cyc();
    chk("uf sticky", 32'(arb_error), 32'h1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      m1_request = 1; m1_address = 32'h6000 + 32'(k * 4); m1_tag = 8'hA0 + 8'(k);
      #1;
      chk("uf cnt1 budget", 32'(m1_ready), 32'(k < 4));
    end
    cyc();
    m1_request = 0;
    respond(9'h1A0, 32'h5555_0000);
    respond(9'h1A1, 32'h5555_0004);
    respond(9'h1A2, 32'h5555_0008);
    respond(9'h1A3, 32'h5555_000C);

    // Async reset with two ifetch reads in flight.
    cyc();
    m0_request = 1; m0_address = 32'h7000; m0_tag = 8'h70;
    cyc();
    m0_address = 32'h7004; m0_tag = 8'h71;
    cyc();
    m0_request = 0;
    #2;
    reset_n = 0;
    #1;
    chk("rst icache_request", 32'(icache_request), 32'h0);
    chk("rst arb_error", 32'(arb_error), 32'h0);
    chk("rst m1_rtag", 32'(m1_rtag), 32'h0);
    chk("rst m0_rdata", m0_rdata, 32'h0);
    chk("rst rvalids", {30'b0, m0_rvalid, m1_rvalid}, 32'h0);
    cyc();
    cyc();
    reset_n = 1; m0_request = 1; m1_request = 1;
    #1;
    chk("rst m0 first", 32'(m0_ready), 32'h1);
    chk("rst m1 waits", 32'(m1_ready), 32'h0);
    cyc();
    m0_request = 0; m1_request = 0;
    cyc();
    icache_rvalid = 1; icache_rtag = 9'h1EE; icache_rdata = 32'h6666_0000; icache_raddr = 32'h7004;
    cyc();
    icache_rvalid = 0;
    #1;
    chk("rst late resp error", 32'(arb_error), 32'h1);
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
